// File: rtl/ipsxe_floating_point_output_encode_v1_0_if.sv
// Bus between the fl2fl input-decode stage and the output-encode back end.
// The slave side is the encoder; the master side is the decode stage (or a bench).
interface ipsxe_floating_point_output_encode_v1_0_if #(
  parameter int unsigned FLOAT_IN_EXP   = 8,
  parameter int unsigned FLOAT_IN_FRAC  = 24,
  parameter int unsigned FLOAT_OUT_EXP  = 11,
  parameter int unsigned FLOAT_OUT_FRAC = 53
) ();

  localparam int unsigned OUT_W = FLOAT_OUT_EXP + FLOAT_OUT_FRAC;

  logic                     i_valid;
  logic                     i_sign;
  logic [FLOAT_IN_EXP-1:0]  i_exp;
  logic [FLOAT_IN_FRAC-2:0] i_frac;
  logic [1:0]               i_case_judge;
  logic                     i_overflow;
  logic                     i_underflow;

  logic                     o_valid;
  logic [OUT_W-1:0]         o_data;
  logic                     o_overflow;
  logic                     o_underflow;
  logic                     o_inexact;

  modport master (
    output i_valid, i_sign, i_exp, i_frac, i_case_judge, i_overflow, i_underflow,
    input  o_valid, o_data, o_overflow, o_underflow, o_inexact
  );

  modport slave (
    input  i_valid, i_sign, i_exp, i_frac, i_case_judge, i_overflow, i_underflow,
    output o_valid, o_data, o_overflow, o_underflow, o_inexact
  );

endinterface

// File: rtl/ipsxe_floating_point_output_encode_v1_0.sv
// Float-to-float conversion back end: special-case substitution, exponent rebias,
// RNE rounding when narrowing, and rounding carry, in a two-stage valid pipeline.
module ipsxe_floating_point_output_encode_v1_0 #(
  parameter int unsigned FLOAT_IN_EXP   = 8,
  parameter int unsigned FLOAT_IN_FRAC  = 24,
  parameter int unsigned FLOAT_OUT_EXP  = 11,
  parameter int unsigned FLOAT_OUT_FRAC = 53
) (
  input  logic i_aclk,
  input  logic i_areset,
  input  logic i_aclken,
  ipsxe_floating_point_output_encode_v1_0_if.slave bus
);

  localparam int unsigned IN_F     = FLOAT_IN_FRAC - 1;
  localparam int unsigned OUT_F    = FLOAT_OUT_FRAC - 1;
  localparam int unsigned EXP_W    = ((FLOAT_IN_EXP > FLOAT_OUT_EXP) ? FLOAT_IN_EXP : FLOAT_OUT_EXP) + 2;
  localparam int unsigned BIAS_IN  = (1 << (FLOAT_IN_EXP - 1)) - 1;
  localparam int unsigned BIAS_OUT = (1 << (FLOAT_OUT_EXP - 1)) - 1;
  localparam int unsigned MAG_W    = FLOAT_OUT_EXP + OUT_F;
  localparam int unsigned OUT_W    = FLOAT_OUT_EXP + FLOAT_OUT_FRAC;

  // Stage-1 pipeline registers
  logic                     s1_valid;
  logic                     s1_sign;
  logic [FLOAT_OUT_EXP-1:0] s1_exp;
  logic [OUT_F-1:0]         s1_frac;
  logic                     s1_inc;
  logic                     s1_inex;
  logic                     s1_norm;

  // Stage-1 next values
  logic                     sign_d;
  logic [FLOAT_OUT_EXP-1:0] exp_d;
  logic [OUT_F-1:0]         frac_d;
  logic                     inc_d;
  logic                     inex_d;
  logic                     norm_d;

  logic [FLOAT_OUT_EXP-1:0] exp_norm;
  logic [OUT_F-1:0]         frac_cvt;
  logic                     round_up;
  logic                     inexact_cvt;

  // Stage-2 combinational results
  logic [MAG_W-1:0]         mag_sum;
  logic                     rnd_ovf;
  logic                     ovf_d;
  logic                     unf_d;
  logic [OUT_W-1:0]         data_d;

  // Rebias in a width wide enough that the intermediate sum never wraps
  assign exp_norm = FLOAT_OUT_EXP'(EXP_W'(bus.i_exp) + EXP_W'(BIAS_OUT) - EXP_W'(BIAS_IN));

  // Fraction alignment: zero-pad when widening, keep top bits and derive RNE when narrowing
  if (OUT_F > IN_F) begin : g_widen
    assign frac_cvt    = {bus.i_frac, {(OUT_F - IN_F){1'b0}}};
    assign round_up    = 1'b0;
    assign inexact_cvt = 1'b0;
  end else if (OUT_F == IN_F) begin : g_same
    assign frac_cvt    = bus.i_frac;
    assign round_up    = 1'b0;
    assign inexact_cvt = 1'b0;
  end else begin : g_narrow
    localparam int unsigned DROP = IN_F - OUT_F;
    logic guard;
    logic sticky;

    assign frac_cvt = bus.i_frac[IN_F-1 -: OUT_F];
    assign guard    = bus.i_frac[DROP-1];

    if (DROP > 1) begin : g_sticky
      assign sticky = |bus.i_frac[DROP-2:0];
    end else begin : g_no_sticky
      assign sticky = 1'b0;
    end

    assign round_up    = guard & (sticky | frac_cvt[0]);
    assign inexact_cvt = guard | sticky;
  end

  // Stage-1 selection: NaN beats flush beats the normal conversion
  always_comb begin
    sign_d = bus.i_sign;
    exp_d  = exp_norm;
    frac_d = frac_cvt;
    inc_d  = round_up;
    inex_d = inexact_cvt;
    norm_d = 1'b1;
    if (bus.i_case_judge[1]) begin
      sign_d = 1'b0;
      exp_d  = '1;
      frac_d = {1'b1, {(OUT_F - 1){1'b0}}};
      inc_d  = 1'b0;
      inex_d = 1'b0;
      norm_d = 1'b0;
    end else if (bus.i_case_judge[0]) begin
      exp_d  = bus.i_exp[FLOAT_IN_EXP-1] ? '1 : '0;
      frac_d = '0;
      inc_d  = 1'b0;
      inex_d = 1'b0;
      norm_d = 1'b0;
    end
  end

  // Rounding carry ripples from the fraction into the exponent
  assign mag_sum = {s1_exp, s1_frac} + MAG_W'(s1_inc);
  assign rnd_ovf = s1_norm & (&mag_sum[MAG_W-1 -: FLOAT_OUT_EXP]);
  assign ovf_d   = bus.i_overflow | rnd_ovf;
  assign unf_d   = bus.i_underflow;

  always_comb begin
    data_d = {s1_sign, mag_sum};
    if (rnd_ovf) begin
      data_d = {s1_sign, {FLOAT_OUT_EXP{1'b1}}, {OUT_F{1'b0}}};
    end
  end

  // Stage 1: capture decoded fields
  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_frac  <= '0;
      s1_inc   <= 1'b0;
      s1_inex  <= 1'b0;
      s1_norm  <= 1'b0;
    end else if (i_aclken) begin
      s1_valid <= bus.i_valid;
      if (bus.i_valid) begin
        s1_sign <= sign_d;
        s1_exp  <= exp_d;
        s1_frac <= frac_d;
        s1_inc  <= inc_d;
        s1_inex <= inex_d;
        s1_norm <= norm_d;
      end
    end
  end

  // Stage 2: result and flags load only with valid data; range flags arrive here
  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      bus.o_valid     <= 1'b0;
      bus.o_data      <= '0;
      bus.o_overflow  <= 1'b0;
      bus.o_underflow <= 1'b0;
      bus.o_inexact   <= 1'b0;
    end else if (i_aclken) begin
      bus.o_valid <= s1_valid;
      if (s1_valid) begin
        bus.o_data      <= data_d;
        bus.o_overflow  <= ovf_d;
        bus.o_underflow <= unf_d;
        bus.o_inexact   <= s1_inex | ovf_d | unf_d;
      end
    end
  end

endmodule

// File: tb/tb_ipsxe_floating_point_output_encode_v1_0.sv
// Directed bench for the fl2fl output encoder: config A widens 8/24->11/53,
// config B narrows 11/53->8/24; both share clock, reset and clock enable.
module tb_ipsxe_floating_point_output_encode_v1_0;

  logic clk = 1'b0;
  logic rst;
  logic aclken;

  int checks = 0;
  int errors = 0;

  ipsxe_floating_point_output_encode_v1_0_if #(
    .FLOAT_IN_EXP(8), .FLOAT_IN_FRAC(24), .FLOAT_OUT_EXP(11), .FLOAT_OUT_FRAC(53)
  ) ifa ();

  ipsxe_floating_point_output_encode_v1_0_if #(
    .FLOAT_IN_EXP(11), .FLOAT_IN_FRAC(53), .FLOAT_OUT_EXP(8), .FLOAT_OUT_FRAC(24)
  ) ifb ();

  ipsxe_floating_point_output_encode_v1_0 #(
    .FLOAT_IN_EXP(8), .FLOAT_IN_FRAC(24), .FLOAT_OUT_EXP(11), .FLOAT_OUT_FRAC(53)
  ) dut_a (
    .i_aclk  (clk),
    .i_areset(rst),
    .i_aclken(aclken),
    .bus     (ifa)
  );

  ipsxe_floating_point_output_encode_v1_0 #(
    .FLOAT_IN_EXP(11), .FLOAT_IN_FRAC(53), .FLOAT_OUT_EXP(8), .FLOAT_OUT_FRAC(24)
  ) dut_b (
    .i_aclk  (clk),
    .i_areset(rst),
    .i_aclken(aclken),
    .bus     (ifb)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One item through config A; range flags follow one enabled cycle behind the data
  task automatic run_a(input logic s, input logic [7:0] e, input logic [22:0] f,
                       input logic [1:0] cj, input logic ovf, input logic unf);
    ifa.i_valid = 1'b1; ifa.i_sign = s; ifa.i_exp = e; ifa.i_frac = f; ifa.i_case_judge = cj;
    step();
    ifa.i_valid = 1'b0; ifa.i_overflow = ovf; ifa.i_underflow = unf;
    chk("a_latency", 64'(ifa.o_valid), 64'd0);
    step();
    ifa.i_overflow = 1'b0; ifa.i_underflow = 1'b0;
    chk("a_valid", 64'(ifa.o_valid), 64'd1);
  endtask

  task automatic run_b(input logic s, input logic [10:0] e, input logic [51:0] f,
                       input logic [1:0] cj, input logic ovf, input logic unf);
    ifb.i_valid = 1'b1; ifb.i_sign = s; ifb.i_exp = e; ifb.i_frac = f; ifb.i_case_judge = cj;
    step();
    ifb.i_valid = 1'b0; ifb.i_overflow = ovf; ifb.i_underflow = unf;
    chk("b_latency", 64'(ifb.o_valid), 64'd0);
    step();
    ifb.i_overflow = 1'b0; ifb.i_underflow = 1'b0;
    chk("b_valid", 64'(ifb.o_valid), 64'd1);
  endtask

  initial begin
    logic [63:0] last_exp;
    logic        exp_valid;
    int          ne;

    rst = 1'b1; aclken = 1'b1;
    ifa.i_valid = 1'b0; ifa.i_sign = 1'b0; ifa.i_exp = '0; ifa.i_frac = '0;
    ifa.i_case_judge = '0; ifa.i_overflow = 1'b0; ifa.i_underflow = 1'b0;
    ifb.i_valid = 1'b0; ifb.i_sign = 1'b0; ifb.i_exp = '0; ifb.i_frac = '0;
    ifb.i_case_judge = '0; ifb.i_overflow = 1'b0; ifb.i_underflow = 1'b0;

    #12;
    chk("rst_valid_a", 64'(ifa.o_valid), 64'd0);
    chk("rst_data_a", ifa.o_data, 64'd0);
    chk("rst_flags_a", 64'({ifa.o_overflow, ifa.o_underflow, ifa.o_inexact}), 64'd0);
    chk("rst_valid_b", 64'(ifb.o_valid), 64'd0);
    chk("rst_data_b", 64'(ifb.o_data), 64'd0);
    rst = 1'b0;
    step();

    // Config A: widening
    run_a(1'b0, 8'h7F, 23'h0, 2'b00, 1'b0, 1'b0);
    chk("a_one_data", ifa.o_data, 64'h3FF0000000000000);
    chk("a_one_flags", 64'({ifa.o_overflow, ifa.o_underflow, ifa.o_inexact}), 64'd0);

    run_a(1'b0, 8'hFF, 23'h400001, 2'b11, 1'b0, 1'b0);
    chk("a_nan_data", ifa.o_data, 64'h7FF8000000000000);
    chk("a_nan_flags", 64'({ifa.o_overflow, ifa.o_underflow, ifa.o_inexact}), 64'd0);

    run_a(1'b0, 8'h00, 23'h5, 2'b01, 1'b0, 1'b0);
    chk("a_denorm_data", ifa.o_data, 64'h0);
    chk("a_denorm_flags", 64'({ifa.o_overflow, ifa.o_underflow, ifa.o_inexact}), 64'd0);

    run_a(1'b1, 8'h80, 23'h400000, 2'b00, 1'b0, 1'b0);
    chk("a_neg3_data", ifa.o_data, 64'hC008000000000000);

    run_a(1'b1, 8'hFF, 23'h0, 2'b01, 1'b0, 1'b0);
    chk("a_neginf_data", ifa.o_data, 64'hFFF0000000000000);
    chk("a_neginf_flags", 64'({ifa.o_overflow, ifa.o_underflow, ifa.o_inexact}), 64'd0);

    // Config B: narrowing with RNE
    run_b(1'b0, 11'h3FF, 52'h0000010000000, 2'b00, 1'b0, 1'b0);
    chk("b_tie_even_data", 64'(ifb.o_data), 64'h3F800000);
    chk("b_tie_even_flags", 64'({ifb.o_overflow, ifb.o_underflow, ifb.o_inexact}), 64'd1);

    run_b(1'b0, 11'h3FF, 52'h0000030000000, 2'b00, 1'b0, 1'b0);
    chk("b_tie_odd_data", 64'(ifb.o_data), 64'h3F800002);
    chk("b_tie_odd_flags", 64'({ifb.o_overflow, ifb.o_underflow, ifb.o_inexact}), 64'd1);

    run_b(1'b0, 11'h3FF, 52'h0000010000001, 2'b00, 1'b0, 1'b0);
    chk("b_sticky_data", 64'(ifb.o_data), 64'h3F800001);

    run_b(1'b0, 11'h3FF, 52'hFFFFFFFFFFFFF, 2'b00, 1'b0, 1'b0);
    chk("b_carry_data", 64'(ifb.o_data), 64'h40000000);
    chk("b_carry_flags", 64'({ifb.o_overflow, ifb.o_underflow, ifb.o_inexact}), 64'd1);

    run_b(1'b0, 11'h400, 52'h8000000000000, 2'b00, 1'b0, 1'b0);
    chk("b_exact_data", 64'(ifb.o_data), 64'h40400000);
    chk("b_exact_flags", 64'({ifb.o_overflow, ifb.o_underflow, ifb.o_inexact}), 64'd0);

    run_b(1'b0, 11'h47E, 52'hFFFFFFFFFFFFF, 2'b00, 1'b0, 1'b0);
    chk("b_rnd_ovf_data", 64'(ifb.o_data), 64'h7F800000);
    chk("b_rnd_ovf_flags", 64'({ifb.o_overflow, ifb.o_underflow, ifb.o_inexact}), 64'b101);

    run_b(1'b0, 11'h300, 52'h0, 2'b01, 1'b0, 1'b1);
    chk("b_unf_data", 64'(ifb.o_data), 64'h0);
    chk("b_unf_flags", 64'({ifb.o_overflow, ifb.o_underflow, ifb.o_inexact}), 64'b011);

    run_b(1'b0, 11'h7FF, 52'h1, 2'b10, 1'b1, 1'b0);
    chk("b_nan_ovf_data", 64'(ifb.o_data), 64'h7FC00000);
    chk("b_nan_ovf_flags", 64'({ifb.o_overflow, ifb.o_underflow, ifb.o_inexact}), 64'b101);

    // Back-to-back items on config A with the clock enable toggling 1010...
    last_exp = 64'hFFF0000000000000;
    ne = 0;
    for (int k = 0; k < 12; k++) begin
      aclken = (k % 2 == 0);
      if (ne < 4) begin
        ifa.i_valid = 1'b1; ifa.i_sign = 1'b0; ifa.i_exp = 8'(128 + ne);
        ifa.i_frac = '0; ifa.i_case_judge = 2'b00;
      end else begin
        ifa.i_valid = 1'b0;
      end
      step();
      if (aclken) ne++;
      exp_valid = (ne >= 2) && (ne <= 5);
      if (exp_valid) last_exp = {1'b0, 11'(1024 + ne - 2), 52'd0};
      chk("b2b_valid", 64'(ifa.o_valid), 64'(exp_valid));
      chk("b2b_data", ifa.o_data, last_exp);
    end
    aclken = 1'b1;
    ifa.i_valid = 1'b0;
    step();
    step();

    // Reset with two items in flight
    ifa.i_valid = 1'b1; ifa.i_sign = 1'b0; ifa.i_exp = 8'h7F; ifa.i_frac = '0; ifa.i_case_judge = 2'b00;
    step();
    ifa.i_exp = 8'h80; ifa.i_overflow = 1'b1;
    step();
    ifa.i_valid = 1'b0; ifa.i_overflow = 1'b0;
    chk("pre_rst_valid", 64'(ifa.o_valid), 64'd1);
    chk("pre_rst_data", ifa.o_data, 64'h3FF0000000000000);
    chk("pre_rst_flags", 64'({ifa.o_overflow, ifa.o_underflow, ifa.o_inexact}), 64'b101);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(ifa.o_valid), 64'd0);
    chk("mid_rst_data", ifa.o_data, 64'd0);
    chk("mid_rst_flags", 64'({ifa.o_overflow, ifa.o_underflow, ifa.o_inexact}), 64'd0);
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_rst_valid", 64'(ifa.o_valid), 64'd0);
    end
    chk("post_rst_data", ifa.o_data, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
